// File: rtl/halt_dump_pkg.sv
// Shared types and constants for the end-of-program halt/dump unit.
// HALT_DUMP_PC_EN adds a trailing PC beat to the dump.
package halt_dump_pkg;
  typedef enum logic [1:0] {RUN, DUMP, DONE} state_e;

  localparam int BEAT_W = 6;
`ifdef HALT_DUMP_PC_EN
  localparam int NUM_BEATS = 34;
`else
  localparam int NUM_BEATS = 33;
`endif
  localparam logic [31:0] HALT_OPCODE = 32'h0000_0000;
endpackage

// File: rtl/halt_dump_cycle_counter.sv
// Saturating execution-cycle counter with enable and synchronous clear.
module halt_dump_cycle_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   count <= '0;
    else if (clr)                 count <= '0;
    else if (en && count != '1)   count <= count + 1'b1;
  end
endmodule

// File: rtl/halt_dump_ctrl.sv
// Halt detection and register/cycle-count dump over a valid/ready port.
// Define HALT_DUMP_PC_EN to append the halting PC as a final beat.
module halt_dump_ctrl
  import halt_dump_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     instruction_word,
  input  logic [63:0]     pc_current,
  output logic            core_stall,
  output logic            halted,
  output logic [4:0]      rf_rd_addr,
  input  logic [XLEN-1:0] rf_rd_data,
  output logic            dump_valid,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_last,
  input  logic            dump_ready
);
  state_e              state;
  logic [BEAT_W-1:0]   beat_idx;
  logic [BEAT_W-1:0]   nxt_idx;
  logic [CNT_W-1:0]    cycles;
  logic [XLEN-1:0]     nxt_data;

  // Counts every RUN edge, including the one that sees the halt opcode.
  halt_dump_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (state == RUN),
    .clr   (1'b0),
    .count (cycles)
  );

`ifdef HALT_DUMP_PC_EN
  logic [63:0] pc_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                               pc_q <= '0;
    else if (state == RUN && instruction_word == HALT_OPCODE) pc_q <= pc_current;
  end
`else
  logic unused_pc;
  assign unused_pc = ^pc_current;
`endif

  assign nxt_idx    = beat_idx + 1'b1;
  // The read port is pre-pointed at the next register so its data is ready at the handshake.
  assign rf_rd_addr = (state == DUMP && nxt_idx < BEAT_W'(NREGS)) ? nxt_idx[4:0] : 5'd0;

  always_comb begin
    nxt_data = '0;
    if (nxt_idx < BEAT_W'(NREGS))       nxt_data = rf_rd_data;
    else if (nxt_idx == BEAT_W'(NREGS)) nxt_data = XLEN'(cycles);
`ifdef HALT_DUMP_PC_EN
    else                                nxt_data = XLEN'(pc_q);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      beat_idx   <= '0;
      core_stall <= 1'b0;
      halted     <= 1'b0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
    end else begin
      case (state)
        RUN: if (instruction_word == HALT_OPCODE) begin
          state      <= DUMP;
          core_stall <= 1'b1;
          halted     <= 1'b1;
          dump_valid <= 1'b1;
          dump_data  <= rf_rd_data;
          dump_last  <= 1'b0;
          beat_idx   <= '0;
        end
        DUMP: if (dump_ready) begin
          if (beat_idx == BEAT_W'(NUM_BEATS - 1)) begin
            state      <= DONE;
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            dump_data  <= '0;
          end else begin
            beat_idx   <= nxt_idx;
            dump_data  <= nxt_data;
            dump_last  <= (nxt_idx == BEAT_W'(NUM_BEATS - 1));
          end
        end
        DONE: ;
        default: state <= RUN;
      endcase
    end
  end
endmodule
